prbs_checker: RTL
=================

Name: prbs_checker

Overview:
- Receive-side companion to the stimulus generators in our test benches.
- Consumes WIDTH-bit words of a PRBS7 stream, each qualified by a valid strobe.
- Self-seeds a local LFSR from the incoming data and declares lock after a run of clean words.
- Once locked, reports per-word bit errors and a saturating error count; sits on the output side of a DUT for on-chip or in-sim link checking.

Parameters:
- WIDTH, 8, bits per input word; must be >= 7.
- LOCK_WORDS, 4, consecutive error-free words required (after seeding) to declare lock; >= 1.
- CNT_WIDTH, 16, width of the error counter.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  i_data holds a word this cycle.
- i_data  input  WIDTH  PRBS word; bit WIDTH-1 is earliest in time.
- i_clr  input  1  synchronous clear of the error counter.
- o_locked  output  1  checker is in LOCKED.
- o_err  output  1  one-cycle pulse: previous valid word had one or more mismatches while LOCKED.
- o_err_cnt  output  CNT_WIDTH  saturating count of mismatched bits while LOCKED.

Behaviour:
- Reset: asynchronous. State=HUNT, LFSR=0, good-word count=0, o_locked=0, o_err=0, o_err_cnt=0.
- Polynomial: x^7+x^6+1, s[n]=s[n-7]^s[n-6]. The LFSR advances WIDTH bits per valid word and holds when i_valid=0.
- Expected word: the next WIDTH generated bits, MSB first. mism = popcount(i_data ^ expected).
- All outputs are registered and update on the clock edge that samples the valid word (visible the following cycle).
- States: HUNT, SYNC, LOCKED.
- HUNT, on valid word:
  - Load the LFSR from the last 7 bits of the word (i_data[6:0]) → SYNC, good count=0.
  - If i_data[6:0]==0 (degenerate seed), remain in HUNT.
- SYNC, on valid word:
  - mism==0: good count +1. When the count reaches LOCK_WORDS → LOCKED.
  - mism!=0: reseed from this word (same rule as HUNT), good count=0, stay SYNC. Drop to HUNT if the seed is 0.
  - No error counting and no o_err while in SYNC.
- LOCKED, on valid word:
  - mism>0: o_err=1 for one cycle; o_err_cnt += mism, saturating at 2^CNT_WIDTH-1.
  - mism > WIDTH/2: loss of sync → HUNT, o_locked=0. This word's errors are still counted.
  - The LFSR keeps free-running; it never reseeds from data while LOCKED.
- i_valid=0: no state, LFSR or counter change; o_err=0.
- i_clr:
  - Loads o_err_cnt=0 and takes priority over a same-cycle increment; that word's errors are discarded.
  - Does not affect lock state or o_err.
- o_locked equals (state==LOCKED), registered.
- Reset asserted mid-stream returns everything to reset values immediately; relock requires a full seed + LOCK_WORDS sequence.

Optional Feature:
- Macro: PRBS_CHECKER_WORD_CNT_EN.
- Defined:
  - Adds output port o_word_cnt [CNT_WIDTH-1:0] for BER computation.
  - Counts valid words received while LOCKED, including the loss-of-sync word; saturating; reset to 0.
  - Cleared by i_clr with the same priority as o_err_cnt.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan (WIDTH=8, LOCK_WORDS=4 unless noted):
1. Reset held, then released with no i_valid → o_locked=0, o_err=0, o_err_cnt=0 indefinitely. Assert i_rst_n=0 asynchronously mid-lock → all outputs 0 before the next edge.
2. Clean PRBS7 stream seeded 7'h7F, i_valid every cycle → o_locked=1 the cycle after the 5th valid word (1 seed + 4 clean); o_err_cnt stays 0 for 100 words. Same stream with i_valid toggling 1/0 → lock after 5 valid words; idle cycles are ignored.
3. Locked, flip bit 3 of one word → o_err=1 for exactly one cycle, o_err_cnt=1, o_locked stays 1; next clean word → o_err=0.
4. Locked, flip 5 bits in one word → o_err_cnt +5, o_locked=0 next cycle. Resume a clean stream → relock after exactly 5 valid words. All-zero input for 50 words → o_locked never asserts.
5. CNT_WIDTH=4, locked, inject 20 single-bit-error words → o_err_cnt saturates at 15 and holds. i_clr → 0 next cycle. i_clr in the same cycle as a 2-bit-error word → o_err_cnt=0 and o_err=1.
6. PRBS_CHECKER_WORD_CNT_EN defined, lock then 10 valid words (i_valid low on 3 interleaved cycles) → o_word_cnt=10; i_clr → 0. Undefined: bench compiles without the o_word_cnt port.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker
//   Receive-side PRBS7 (x^7 + x^6 + 1) checker. Seeds a local LFSR from the
//   incoming stream, declares lock after LOCK_WORDS clean words, then reports
//   per-word mismatches and a saturating mismatched-bit count.
//
// Parameters
//   WIDTH      bits per input word (>= 7)
//   LOCK_WORDS clean words after seeding needed to lock (>= 1)
//   CNT_WIDTH  width of the saturating counters
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_valid    i_data carries a word this cycle
//   i_data     PRBS word, bit WIDTH-1 earliest in time
//   i_clr      synchronous clear of the counters (wins over an increment)
//   o_locked   checker is in LOCKED (registered)
//   o_err      one-cycle pulse: last valid word mismatched while LOCKED
//   o_err_cnt  saturating count of mismatched bits while LOCKED
//   o_word_cnt saturating count of valid words while LOCKED
//              (only when PRBS_CHECKER_WORD_CNT_EN is defined)
module prbs_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_WORDS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_clr,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_err_cnt
`ifdef PRBS_CHECKER_WORD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_word_cnt
`endif
);

    localparam int MW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(LOCK_WORDS + 1);
    localparam logic [MW-1:0] HALF = MW'(WIDTH / 2);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t           state;
    logic [6:0]       lfsr;       // lfsr[6] is the oldest of the last 7 bits
    logic [GW-1:0]    good_cnt;

    logic [6:0]       st;
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] diff;
    logic [MW-1:0]    mism;
    logic [GW-1:0]    good_nxt;
    logic             seed_zero;
    logic [CNT_WIDTH:0]   err_sum;
    logic [CNT_WIDTH-1:0] err_inc;

    // Unroll WIDTH steps of the generator; first generated bit lands in the MSB.
    always_comb begin
        st       = lfsr;
        exp_word = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            st          = {st[5:0], st[6] ^ st[5]};
            exp_word[i] = st[0];
        end
    end

    always_comb begin
        diff = i_data ^ exp_word;
        mism = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mism = mism + MW'(diff[i]);
        end
    end

    assign good_nxt  = good_cnt + GW'(1);
    assign seed_zero = (i_data[6:0] == 7'd0);

    // One extra bit catches overflow so the counter can pin at all-ones.
    assign err_sum = {1'b0, o_err_cnt} + (CNT_WIDTH + 1)'(mism);
    assign err_inc = err_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= HUNT;
            lfsr       <= '0;
            good_cnt   <= '0;
            o_locked   <= 1'b0;
            o_err      <= 1'b0;
            o_err_cnt  <= '0;
`ifdef PRBS_CHECKER_WORD_CNT_EN
            o_word_cnt <= '0;
`endif
        end else begin
            o_err <= 1'b0;
            if (i_valid) begin
                case (state)
                    HUNT: begin
                        // The last 7 bits of a word fully determine the LFSR state.
                        lfsr     <= i_data[6:0];
                        good_cnt <= '0;
                        if (!seed_zero) state <= SYNC;
                    end
                    SYNC: begin
                        if (mism == '0) begin
                            lfsr     <= exp_word[6:0];
                            good_cnt <= good_nxt;
                            if (good_nxt == GW'(LOCK_WORDS)) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end
                        end else begin
                            lfsr     <= i_data[6:0];
                            good_cnt <= '0;
                            if (seed_zero) state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Free-runs: never reseeds from data once locked.
                        lfsr <= exp_word[6:0];
`ifdef PRBS_CHECKER_WORD_CNT_EN
                        if (o_word_cnt != {CNT_WIDTH{1'b1}})
                            o_word_cnt <= o_word_cnt + CNT_WIDTH'(1);
`endif
                        if (mism != '0) begin
                            o_err     <= 1'b1;
                            o_err_cnt <= err_inc;
                        end
                        // More than half the bits wrong means we lost alignment.
                        if (mism > HALF) begin
                            state    <= HUNT;
                            o_locked <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        o_locked <= 1'b0;
                    end
                endcase
            end
            // Placed last so a clear overrides any same-cycle increment.
            if (i_clr) begin
                o_err_cnt  <= '0;
`ifdef PRBS_CHECKER_WORD_CNT_EN
                o_word_cnt <= '0;
`endif
            end
        end
    end

endmodule
